// File: rtl/coin_vend_fsm.sv
// coin_vend_fsm -- coin-operated vending controller.
//
// Accepts coins of 1, 2 or 3 units per clock and accumulates credit until the
// price is reached, then issues a one-cycle vend pulse. A cancel request
// refunds the credit, including any coin that arrives on the same edge.
// Every output is registered or decoded from registered state only, so it
// never depends combinationally on Din or Cancel.
//
// Optional feature:
//   COIN_CHANGE_EN  When defined, the vend cycle returns the overpayment on
//                   Change (sum - PRICE). When undefined, the overpayment is
//                   kept and Change reads 0 in the vend cycle.
//
// Parameters:
//   PRICE    vend price in coin units, legal range 1 .. 2**CNT_W - 4
//   CNT_W    width of the credit and change datapath
//
// Ports:
//   Clk      input         system clock; all state changes on its rising edge
//   Reset_n  input         asynchronous active-low reset
//   Din      input  [1:0]  coin value this cycle (00 none, 01 one, 10 two, 11 three)
//   Cancel   input         abort request; refunds the credit when it is non-zero
//   Dout     output        vend pulse, high for the single VEND cycle
//   Refund   output        refund pulse, high for the single REFUND cycle
//   Change   output [W]    amount returned; non-zero only in VEND or REFUND
//   Credit   output [W]    current accumulated credit

module coin_vend_fsm #(
  parameter int unsigned PRICE = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [1:0]       Din,
  input  logic             Cancel,
  output logic             Dout,
  output logic             Refund,
  output logic [CNT_W-1:0] Change,
  output logic [CNT_W-1:0] Credit
);

  localparam logic [CNT_W-1:0] PriceW = CNT_W'(PRICE);

  // One-hot encoding leaves twelve illegal codes; each one falls to the
  // default branch and returns to StIdle with cleared registers.
  typedef enum logic [3:0] {
    StIdle   = 4'b0001,
    StAccum  = 4'b0010,
    StVend   = 4'b0100,
    StRefund = 4'b1000
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] credit_q, credit_d;
  logic [CNT_W-1:0] change_q, change_d;
  logic [CNT_W-1:0] sum;
  logic [CNT_W-1:0] vend_change;

  // The binary value of Din equals its coin value. With PRICE at most
  // 2**CNT_W - 4, credit stays below PRICE, so credit + 3 cannot wrap.
  assign sum = credit_q + CNT_W'(Din);

`ifdef COIN_CHANGE_EN
  assign vend_change = sum - PriceW;
`else
  assign vend_change = '0;
`endif

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    change_d = '0;
    case (state_q)
      StIdle, StAccum: begin
        if (Cancel && (sum != '0)) begin
          // Cancel wins over reaching the price on the same edge; the coin
          // arriving with it is part of the refund.
          state_d  = StRefund;
          credit_d = '0;
          change_d = sum;
        end else if (sum >= PriceW) begin
          state_d  = StVend;
          credit_d = '0;
          change_d = vend_change;
        end else if (sum != '0) begin
          state_d  = StAccum;
          credit_d = sum;
        end else begin
          // No coin and no credit; a lone Cancel has nothing to refund.
          state_d  = StIdle;
          credit_d = '0;
        end
      end
      StVend, StRefund: begin
        // Single-cycle states; coins presented now are not counted.
        state_d  = StIdle;
        credit_d = '0;
        change_d = '0;
      end
      default: begin
        state_d  = StIdle;
        credit_d = '0;
        change_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= StIdle;
      credit_q <= '0;
      change_q <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      change_q <= change_d;
    end
  end

  // Decoded by full compare so an illegal code never pulses an output.
  assign Dout   = (state_q == StVend);
  assign Refund = (state_q == StRefund);
  assign Change = change_q;
  assign Credit = credit_q;

endmodule

// File: doc/coin_vend_fsm.md
COIN_VEND_FSM -- requirements
Module: coin_vend_fsm

Interface
REQ-001 The block SHALL have parameter PRICE, default 4, vend price in coin units; legal range 1 <= PRICE <= 2^CNT_W - 4.
REQ-002 The block SHALL have parameter CNT_W, default 4, width of the credit and change datapath.
REQ-003 The block SHALL have port Clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port Din  input  2  coin inputs sampled each Clk: Din[0] = 1 unit, Din[1] = 2 units, both = 3 units, 00 = none.
REQ-006 The block SHALL have port Cancel  input  1  level-sampled request to abort the transaction and refund the credit.
REQ-007 The block SHALL have port Dout  output  1  vend pulse, high for exactly one cycle in state VEND.
REQ-008 The block SHALL have port Refund  output  1  refund pulse, high for exactly one cycle in state REFUND.
REQ-009 The block SHALL have port Change  output  CNT_W  amount returned; non-zero only in VEND or REFUND.
REQ-010 The block SHALL have port Credit  output  CNT_W  current accumulated credit.

Function
REQ-011 The FSM SHALL have four states: IDLE (credit 0), ACCUM (0 < credit < PRICE), VEND and REFUND.
REQ-012 All outputs SHALL be Moore outputs: registered and decoded from state and registers only, never directly from Din or Cancel.
REQ-013 In IDLE or ACCUM each cycle, sum = Credit + coin value, computed CNT_W bits wide; no overflow is possible within the legal PRICE range.
REQ-014 Cancel = 1 in IDLE/ACCUM with sum > 0 SHALL transition to REFUND, latch Change = sum and clear Credit; Cancel has priority over reaching PRICE in the same cycle.
REQ-015 Cancel = 1 with sum = 0 SHALL be ignored and the FSM stays in IDLE.
REQ-016 With Cancel = 0 and sum >= PRICE, the FSM SHALL go to VEND, clear Credit and latch Change per REQ-025/REQ-026.
REQ-017 With Cancel = 0 and 0 < sum < PRICE, the FSM SHALL go to (or stay in) ACCUM with Credit = sum.
REQ-018 With Cancel = 0 and sum = 0, the FSM SHALL stay in IDLE.
REQ-019 VEND and REFUND SHALL last exactly one cycle, then unconditionally return to IDLE with Change = 0.
REQ-020 Din and Cancel SHALL be ignored in VEND and REFUND; coins presented in those cycles are lost.
REQ-021 Latency SHALL be one cycle: the coin edge that reaches PRICE produces Dout = 1 in the next cycle.
REQ-022 An illegal state encoding SHALL recover to IDLE on the next edge with all registers cleared.

Reset
REQ-023 Reset_n = 0 SHALL asynchronously force state IDLE, Credit = 0, Change = 0, Dout = 0 and Refund = 0, including mid-transaction (credit discarded, no refund pulse).
REQ-024 After Reset_n is released, the first Clk edge SHALL sample Din normally.

Configuration
REQ-025 With macro COIN_CHANGE_EN defined, VEND SHALL latch Change = sum - PRICE (overpayment returned).
REQ-026 Without COIN_CHANGE_EN, Change SHALL be 0 in VEND (overpayment absorbed); REFUND behaviour is unchanged.

Verification
REQ-027 The bench SHALL cover (PRICE=4): Din 01,01,01,01 on consecutive edges -> Credit 1,2,3; Dout = 1 for one cycle after the 4th edge; Change = 0; then IDLE.
REQ-028 The bench SHALL cover: Din 11 then 10 -> Credit 3, then VEND with Change = 1 under COIN_CHANGE_EN, and Change = 0 without it.
REQ-029 The bench SHALL cover: Din 10, then Cancel = 1 with Din 01 on the same edge -> Refund = 1 for one cycle, Change = 3, Dout = 0, then Credit = 0.
REQ-030 The bench SHALL cover: Din 11 then Din 01 with Cancel = 1 (sum = 4 = PRICE) -> REFUND with Change = 4 and no Dout.
REQ-031 The bench SHALL cover: Din 11 held during the VEND cycle -> that coin is ignored and Credit = 0 in the following IDLE cycle.
REQ-032 The bench SHALL cover: Credit = 3, then Reset_n pulsed low between edges -> all outputs 0 immediately, Refund never asserted; also PRICE=9, CNT_W=5 with three 11 coins -> VEND and Change = 0.
